mem_access_stage: RTL

// - Memory stage between the EX/MEM latch and writeback; owns the MEM/WB register.
// - Issues one dcache request per load/store, stalls the pipeline until dhit, and never re-issues a completed access.
// - Holds the core's LL/SC link register; coherence snoops invalidate it.
// - Selects and registers the writeback value and control for WB.

---
 rtl/cpu_types_pkg.sv | 16 +
 rtl/link_reg.sv | 22 ++
 rtl/mem_access_stage.sv | 91 +++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: shared datapath types, memory-stage FSM states, link register layout and rdSel codes.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  localparam int REG_W = 5;
  typedef logic [WORD_W-1:0] word_t;
  typedef logic [REG_W-1:0] regbits_t;
  typedef enum logic [1:0] {MA_IDLE, MA_WAIT, MA_HOLD} mem_state_t;
  typedef struct packed {logic valid; logic [WORD_W-3:0] addr;} link_t;
  localparam logic [2:0] RDSEL_ALU = 3'd0;
  localparam logic [2:0] RDSEL_LOAD = 3'd1;
  localparam logic [2:0] RDSEL_NPC = 3'd2;
  localparam logic [2:0] RDSEL_LUI = 3'd3;
  function automatic logic [WORD_W-3:0] wordAddr(word_t a);
    return a[WORD_W-1:2];
  endfunction
endpackage

// File: rtl/link_reg.sv
// link_reg: LL/SC link register; a new LL wins over any same-cycle clear.
module link_reg
  import cpu_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  setEn,
  input  logic  storeDone,
  input  logic  ccinv,
  input  word_t addr,
  input  word_t ccsnoopaddr,
  output logic  match
);
  link_t link;
  logic snoopHit;
  assign match = link.valid && link.addr == wordAddr(addr);
  assign snoopHit = ccinv && link.addr == wordAddr(ccsnoopaddr);
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) link <= '0;
    else if (setEn) link <= {1'b1, wordAddr(addr)};
    else if (snoopHit || (storeDone && match)) link.valid <= 1'b0;
endmodule

// File: rtl/mem_access_stage.sv
// mem_access_stage: issues one dcache access per load/store, stalls until dhit, and owns MEM/WB.
module mem_access_stage
  import cpu_types_pkg::*;
(
  input  logic       CLK,
  input  logic       nRST,
  input  logic       en,
  input  logic       flush,
  input  logic       dREN,
  input  logic       dWEN,
  input  logic       ll,
  input  logic       sc,
  input  word_t      port_out,
  input  word_t      rdat2,
  input  word_t      zeroExt,
  input  word_t      npc,
  input  regbits_t   rd,
  input  logic       regWr,
  input  logic [2:0] rdSel,
  input  logic       halt,
  input  logic       dhit,
  input  word_t      dmemload,
  input  logic       ccinv,
  input  word_t      ccsnoopaddr,
  output logic       dmemREN,
  output logic       dmemWEN,
  output word_t      dmemaddr,
  output word_t      dmemstore,
  output logic       mem_stall,
  output word_t      wb_data,
  output regbits_t   wb_rd,
  output logic       wb_regWr,
  output logic       wb_halt
);
  mem_state_t state, nextState;
  logic linkMatch, active, req, update, bubble, pendFlush, scVal;
  word_t holdBuf, memWord, wbNext;

  link_reg linkReg (
    .CLK(CLK), .nRST(nRST), .setEn(ll && dmemREN && dhit), .storeDone(dmemWEN && dhit),
    .ccinv(ccinv), .addr(port_out), .ccsnoopaddr(ccsnoopaddr), .match(linkMatch)
  );

  // requests are gated by reset so the bus is quiet the instant nRST falls
  assign active = nRST && state != MA_HOLD;
  assign dmemREN = active && dREN;
  assign dmemWEN = active && dWEN && (!sc || linkMatch);
  assign req = dmemREN || dmemWEN;
  assign mem_stall = req && !dhit;
  assign update = en && !mem_stall;
  assign bubble = flush || pendFlush;
  assign dmemaddr = port_out;
  assign dmemstore = rdat2;
  assign memWord = state == MA_HOLD ? holdBuf : dmemload;
  assign scVal = state == MA_HOLD || (dmemWEN && dhit);
  assign wbNext = sc ? word_t'(scVal) :
                  rdSel == RDSEL_ALU ? port_out :
                  rdSel == RDSEL_LOAD ? memWord :
                  rdSel == RDSEL_NPC ? npc :
                  rdSel == RDSEL_LUI ? zeroExt : '0;

  always_comb begin
    nextState = state;
    if (state == MA_HOLD) nextState = en ? MA_IDLE : MA_HOLD;
    else if (!req) nextState = MA_IDLE;
    else if (dhit) nextState = en ? MA_IDLE : MA_HOLD;
    else nextState = MA_WAIT;
  end

  // a flush seen while the access is outstanding is remembered until the result retires
  always_ff @(posedge CLK or negedge nRST)
    if (!nRST) begin
      state <= MA_IDLE;
      pendFlush <= 1'b0;
      holdBuf <= '0;
      wb_data <= '0;
      wb_rd <= '0;
      wb_regWr <= 1'b0;
      wb_halt <= 1'b0;
    end else begin
      state <= nextState;
      if (req && dhit) holdBuf <= dmemload;
      if (update) begin
        pendFlush <= 1'b0;
        wb_data <= bubble ? '0 : wbNext;
        wb_rd <= bubble ? '0 : rd;
        wb_regWr <= !bubble && regWr;
        wb_halt <= !bubble && halt;
      end else if (flush && (req || state == MA_HOLD)) pendFlush <= 1'b1;
    end
endmodule
